// File: rtl/axi_wr_arbiter.sv
// Round-robin arbiter sharing one AXI write master (AW/W/B) among NREQ requesters.
// Optional B-response timeout with stale-response drain: define AXI_WR_ARB_TIMEOUT_EN.
module axi_wr_arbiter #(
  parameter int NREQ      = 2,
  parameter int AW        = 32,
  parameter int DW        = 64,
  parameter int TO_CYCLES = 255
) (
  input  logic                   axi_aclk,
  input  logic                   axi_areset,
  input  logic [NREQ-1:0]        req_awvalid,
  output logic [NREQ-1:0]        req_awready,
  input  logic [NREQ*AW-1:0]     req_awaddr,
  input  logic [NREQ*8-1:0]      req_awlen,
  input  logic [NREQ*3-1:0]      req_awsize,
  input  logic [NREQ*2-1:0]      req_awburst,
  input  logic [NREQ-1:0]        req_wvalid,
  output logic [NREQ-1:0]        req_wready,
  input  logic [NREQ*DW-1:0]     req_wdata,
  input  logic [NREQ*(DW/8)-1:0] req_wstrb,
  output logic [NREQ-1:0]        req_bvalid,
  input  logic [NREQ-1:0]        req_bready,
  output logic [1:0]             req_bresp,
  output logic [AW-1:0]          m_awaddr,
  output logic [7:0]             m_awlen,
  output logic [2:0]             m_awsize,
  output logic [1:0]             m_awburst,
  output logic                   m_awvalid,
  input  logic                   m_awready,
  output logic [DW-1:0]          m_wdata,
  output logic [DW/8-1:0]        m_wstrb,
  output logic                   m_wlast,
  output logic                   m_wvalid,
  input  logic                   m_wready,
  input  logic [1:0]             m_bresp,
  input  logic                   m_bvalid,
  output logic                   m_bready,
  output logic [NREQ-1:0]        grant,
  output logic                   busy,
  output logic                   err_timeout
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SW = DW / 8;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t          state;
  logic [PW-1:0]   gidx;
  logic [PW-1:0]   ptr;
  logic [7:0]      cnt;
  logic            to_hit;
  logic            stale;

  logic            in_idle, in_addr, in_data, in_resp;
  logic            rsp_done;
  logic [PW-1:0]   pick_idx, cand;
  logic            pick_found;

  assign in_idle = (state == IDLE);
  assign in_addr = (state == ADDR);
  assign in_data = (state == DATA);
  assign in_resp = (state == RESP);

  // First requester at or above ptr, wrapping, so the last one served ranks lowest.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = PW'((int'(ptr) + k) % NREQ);
      if (!pick_found && req_awvalid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign m_awvalid   = in_addr & req_awvalid[gidx];
  assign m_awaddr    = in_addr ? req_awaddr[int'(gidx)*AW +: AW] : '0;
  assign m_awlen     = in_addr ? req_awlen[int'(gidx)*8 +: 8] : '0;
  assign m_awsize    = in_addr ? req_awsize[int'(gidx)*3 +: 3] : '0;
  assign m_awburst   = in_addr ? req_awburst[int'(gidx)*2 +: 2] : '0;
  assign req_awready = in_addr ? (grant & {NREQ{m_awready}}) : '0;

  assign m_wvalid    = in_data & req_wvalid[gidx];
  assign m_wdata     = in_data ? req_wdata[int'(gidx)*DW +: DW] : '0;
  assign m_wstrb     = in_data ? req_wstrb[int'(gidx)*SW +: SW] : '0;
  assign m_wlast     = in_data & (cnt == 8'd0);
  assign req_wready  = in_data ? (grant & {NREQ{m_wready}}) : '0;

  // A timed-out burst answers the requester locally; the real B is drained later in IDLE.
  assign req_bvalid  = in_resp ? (grant & {NREQ{m_bvalid | to_hit}}) : '0;
  assign req_bresp   = in_resp ? (to_hit ? 2'b10 : m_bresp) : 2'b00;
  assign m_bready    = (in_resp & ~to_hit & req_bready[gidx]) | (in_idle & stale);
  assign rsp_done    = to_hit ? req_bready[gidx] : (m_bvalid & req_bready[gidx]);

  assign busy        = ~in_idle;

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      state <= IDLE;
      grant <= '0;
      gidx  <= '0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found && !stale) begin
            grant <= NREQ'(1) << pick_idx;
            gidx  <= pick_idx;
            state <= ADDR;
          end
        end
        ADDR: begin
          if (m_awvalid && m_awready) begin
            cnt   <= m_awlen;
            state <= DATA;
          end
        end
        DATA: begin
          if (m_wvalid && m_wready) begin
            if (cnt == 8'd0) state <= RESP;
            else             cnt   <= cnt - 8'd1;
          end
        end
        RESP: begin
          if (rsp_done) begin
            ptr   <= (gidx == PW'(NREQ - 1)) ? '0 : gidx + 1'b1;
            grant <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef AXI_WR_ARB_TIMEOUT_EN
  logic [15:0] to_cnt;

  // to_hit rises on the edge ending RESP cycle TO_CYCLES-1, so the timeout shows in cycle TO_CYCLES.
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      to_cnt      <= '0;
      to_hit      <= 1'b0;
      stale       <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      if (in_data) begin
        to_cnt <= '0;
        to_hit <= 1'b0;
      end else if (in_resp && !to_hit && !m_bvalid) begin
        to_cnt <= to_cnt + 16'd1;
        if (to_cnt == 16'(TO_CYCLES - 2)) begin
          to_hit      <= 1'b1;
          err_timeout <= 1'b1;
        end
      end
      if (in_resp && to_hit && req_bready[gidx]) begin
        stale  <= 1'b1;
        to_hit <= 1'b0;
      end else if (in_idle && stale && m_bvalid) begin
        stale <= 1'b0;
      end
    end
  end
`else
  assign to_hit      = 1'b0;
  assign stale       = 1'b0;
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Directed bench for axi_wr_arbiter: per-cycle vector table plus burst sequences.
module tb_axi_wr_arbiter;

  localparam int NREQ = 2;
  localparam int AW   = 32;
  localparam int DW   = 64;
  localparam int TO   = 16;

  logic                   axi_aclk = 1'b0;
  logic                   axi_areset = 1'b1;
  logic [NREQ-1:0]        req_awvalid = '0;
  logic [NREQ-1:0]        req_awready;
  logic [NREQ*AW-1:0]     req_awaddr = {32'h0000_2000, 32'h0000_1000};
  logic [NREQ*8-1:0]      req_awlen = '0;
  logic [NREQ*3-1:0]      req_awsize = {3'b011, 3'b011};
  logic [NREQ*2-1:0]      req_awburst = {2'b01, 2'b01};
  logic [NREQ-1:0]        req_wvalid = '0;
  logic [NREQ-1:0]        req_wready;
  logic [NREQ*DW-1:0]     req_wdata = '0;
  logic [NREQ*(DW/8)-1:0] req_wstrb = '1;
  logic [NREQ-1:0]        req_bvalid;
  logic [NREQ-1:0]        req_bready = '0;
  logic [1:0]             req_bresp;
  logic [AW-1:0]          m_awaddr;
  logic [7:0]             m_awlen;
  logic [2:0]             m_awsize;
  logic [1:0]             m_awburst;
  logic                   m_awvalid;
  logic                   m_awready = 1'b0;
  logic [DW-1:0]          m_wdata;
  logic [DW/8-1:0]        m_wstrb;
  logic                   m_wlast;
  logic                   m_wvalid;
  logic                   m_wready = 1'b0;
  logic [1:0]             m_bresp = 2'b00;
  logic                   m_bvalid = 1'b0;
  logic                   m_bready;
  logic [NREQ-1:0]        grant;
  logic                   busy;
  logic                   err_timeout;

  int checks   = 0;
  int failures = 0;

  axi_wr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TO_CYCLES(TO)) dut (
    .axi_aclk(axi_aclk), .axi_areset(axi_areset),
    .req_awvalid(req_awvalid), .req_awready(req_awready), .req_awaddr(req_awaddr),
    .req_awlen(req_awlen), .req_awsize(req_awsize), .req_awburst(req_awburst),
    .req_wvalid(req_wvalid), .req_wready(req_wready), .req_wdata(req_wdata),
    .req_wstrb(req_wstrb), .req_bvalid(req_bvalid), .req_bready(req_bready),
    .req_bresp(req_bresp), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
    .m_awburst(m_awburst), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid),
    .m_wready(m_wready), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .grant(grant), .busy(busy), .err_timeout(err_timeout)
  );

  always #5 axi_aclk = ~axi_aclk;

  typedef struct {
    logic       rst;
    logic [1:0] awv;
    logic [1:0] wv;
    logic [7:0] len0;
    logic [7:0] len1;
    logic       bv;
    logic [1:0] br;
    logic [1:0] e_grant;
    logic       e_awv;
    logic [31:0] e_addr;
    logic       e_wv;
    logic       e_wlast;
    logic [1:0] e_bv;
    logic       e_bready;
    logic       e_busy;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic [1:0] awv, input logic [1:0] wv,
                              input logic [7:0] len0, input logic [7:0] len1, input logic bv,
                              input logic [1:0] br, input logic [1:0] g, input logic eaw,
                              input logic [31:0] addr, input logic ewv, input logic ewl,
                              input logic [1:0] ebv, input logic ebr, input logic ebusy);
    vec_t v;
    v.rst = rst; v.awv = awv; v.wv = wv; v.len0 = len0; v.len1 = len1; v.bv = bv; v.br = br;
    v.e_grant = g; v.e_awv = eaw; v.e_addr = addr; v.e_wv = ewv; v.e_wlast = ewl;
    v.e_bv = ebv; v.e_bready = ebr; v.e_busy = ebusy;
    return v;
  endfunction

  function automatic logic [63:0] pat(input int r, input int beat);
    return 64'hD000_0000_0000_0000 | (64'(r) << 32) | 64'(beat);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge axi_aclk); #1;
    axi_areset  = 1'b1;
    req_awvalid = '0; req_wvalid = '0; req_bready = '0;
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = 2'b00;
    @(posedge axi_aclk); #1;
    axi_areset = 1'b0;
  endtask

  // Address then data phase for requester r; stops early after stop_after beats when >= 0.
  task automatic send_burst(input int r, input int len, input bit toggle, input int stop_after);
    int beat;
    int cyc;
    logic [7:0] l8;
    l8 = len[7:0];
    @(posedge axi_aclk); #1;
    req_awvalid = '0;
    req_awvalid[r] = 1'b1;
    req_awlen[r*8 +: 8] = l8;
    req_wvalid = 2'b11;
    req_wdata = {64'hBAD0_BAD0_BAD0_BAD0, 64'hBAD0_BAD0_BAD0_BAD0};
    m_awready = 1'b1;
    @(negedge axi_aclk);
    @(posedge axi_aclk); #1;
    @(negedge axi_aclk);
    chk($sformatf("r%0d awvalid", r), 64'(m_awvalid), 64'd1);
    chk($sformatf("r%0d grant", r), 64'(grant), 64'(1) << r);
    chk($sformatf("r%0d awlen", r), 64'(m_awlen), 64'(l8));
    @(posedge axi_aclk); #1;
    req_awvalid = '0;
    beat = 0;
    cyc  = 0;
    while (beat <= len && beat != stop_after && cyc < 1000) begin
      m_wready = toggle ? ~cyc[0] : 1'b1;
      req_wdata[r*DW +: DW] = pat(r, beat);
      @(negedge axi_aclk);
      chk($sformatf("r%0d wvalid c%0d", r, cyc), 64'(m_wvalid), 64'd1);
      chk($sformatf("r%0d wlast b%0d", r, beat), 64'(m_wlast), 64'(beat == len));
      if (m_wvalid && m_wready) begin
        chk($sformatf("r%0d wdata b%0d", r, beat), m_wdata, pat(r, beat));
        beat++;
      end
      @(posedge axi_aclk); #1;
      cyc++;
    end
    if (stop_after < 0) begin
      m_wready   = 1'b0;
      req_wvalid = '0;
      chk($sformatf("r%0d beats", r), 64'(beat), 64'(len + 1));
    end
  endtask

  task automatic respond(input int r, input logic [1:0] resp);
    m_bvalid = 1'b1;
    m_bresp  = resp;
    req_bready[r] = 1'b1;
    @(negedge axi_aclk);
    chk($sformatf("r%0d bvalid", r), 64'(req_bvalid), 64'(1) << r);
    chk($sformatf("r%0d bresp", r), 64'(req_bresp), 64'(resp));
    chk($sformatf("r%0d bready", r), 64'(m_bready), 64'd1);
    @(posedge axi_aclk); #1;
    m_bvalid   = 1'b0;
    req_bready = '0;
    @(negedge axi_aclk);
    chk($sformatf("r%0d grant after B", r), 64'(grant), 64'd0);
    chk($sformatf("r%0d busy after B", r), 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached checks=%0d", checks);
    $fatal(1);
  end

  vec_t tbl[20];

  initial begin
    // rst, awv, wv, len0, len1, bv, br | grant, awvalid, awaddr, wvalid, wlast, bvalid, bready, busy
    tbl[0]  = mk(1, 2'b00, 2'b00, 3, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0);
    tbl[1]  = mk(0, 2'b01, 2'b01, 3, 0, 0, 2'b01, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0);
    tbl[2]  = mk(0, 2'b01, 2'b01, 3, 0, 0, 2'b01, 2'b01, 1, 32'h1000, 0, 0, 2'b00, 0, 1);
    tbl[3]  = mk(0, 2'b00, 2'b01, 3, 0, 0, 2'b01, 2'b01, 0, 0, 1, 0, 2'b00, 0, 1);
    tbl[4]  = mk(0, 2'b00, 2'b01, 3, 0, 0, 2'b01, 2'b01, 0, 0, 1, 0, 2'b00, 0, 1);
    tbl[5]  = mk(0, 2'b00, 2'b01, 3, 0, 0, 2'b01, 2'b01, 0, 0, 1, 0, 2'b00, 0, 1);
    tbl[6]  = mk(0, 2'b00, 2'b01, 3, 0, 0, 2'b01, 2'b01, 0, 0, 1, 1, 2'b00, 0, 1);
    tbl[7]  = mk(0, 2'b00, 2'b00, 3, 0, 1, 2'b01, 2'b01, 0, 0, 0, 0, 2'b01, 1, 1);
    tbl[8]  = mk(0, 2'b00, 2'b00, 3, 0, 0, 2'b01, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0);
    tbl[9]  = mk(1, 2'b11, 2'b11, 0, 0, 0, 2'b11, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0);
    tbl[10] = mk(0, 2'b11, 2'b11, 0, 0, 0, 2'b11, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0);
    tbl[11] = mk(0, 2'b11, 2'b11, 0, 0, 0, 2'b11, 2'b01, 1, 32'h1000, 0, 0, 2'b00, 0, 1);
    tbl[12] = mk(0, 2'b11, 2'b11, 0, 0, 0, 2'b11, 2'b01, 0, 0, 1, 1, 2'b00, 0, 1);
    tbl[13] = mk(0, 2'b11, 2'b11, 0, 0, 1, 2'b11, 2'b01, 0, 0, 0, 0, 2'b01, 1, 1);
    tbl[14] = mk(0, 2'b11, 2'b11, 0, 0, 0, 2'b11, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0);
    tbl[15] = mk(0, 2'b11, 2'b11, 0, 0, 0, 2'b11, 2'b10, 1, 32'h2000, 0, 0, 2'b00, 0, 1);
    tbl[16] = mk(0, 2'b11, 2'b11, 0, 0, 0, 2'b11, 2'b10, 0, 0, 1, 1, 2'b00, 0, 1);
    tbl[17] = mk(0, 2'b11, 2'b11, 0, 0, 1, 2'b11, 2'b10, 0, 0, 0, 0, 2'b10, 1, 1);
    tbl[18] = mk(0, 2'b11, 2'b11, 0, 0, 0, 2'b11, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0);
    tbl[19] = mk(0, 2'b11, 2'b11, 0, 0, 0, 2'b11, 2'b01, 1, 32'h1000, 0, 0, 2'b00, 0, 1);

    repeat (2) @(posedge axi_aclk);
    m_awready = 1'b1;
    m_wready  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge axi_aclk); #1;
      axi_areset  = tbl[i].rst;
      req_awvalid = tbl[i].awv;
      req_wvalid  = tbl[i].wv;
      req_awlen   = {tbl[i].len1, tbl[i].len0};
      m_bvalid    = tbl[i].bv;
      req_bready  = tbl[i].br;
      @(negedge axi_aclk);
      chk($sformatf("row%0d grant", i), 64'(grant), 64'(tbl[i].e_grant));
      chk($sformatf("row%0d awvalid", i), 64'(m_awvalid), 64'(tbl[i].e_awv));
      chk($sformatf("row%0d awaddr", i), 64'(m_awaddr), 64'(tbl[i].e_addr));
      chk($sformatf("row%0d wvalid", i), 64'(m_wvalid), 64'(tbl[i].e_wv));
      chk($sformatf("row%0d wlast", i), 64'(m_wlast), 64'(tbl[i].e_wlast));
      chk($sformatf("row%0d bvalid", i), 64'(req_bvalid), 64'(tbl[i].e_bv));
      chk($sformatf("row%0d bready", i), 64'(m_bready), 64'(tbl[i].e_bready));
      chk($sformatf("row%0d busy", i), 64'(busy), 64'(tbl[i].e_busy));
    end

    // Backpressure: wready 1,0,1,0... over an 8-beat burst, then EXOKAY response.
    do_reset();
    send_burst(0, 7, 1'b1, -1);
    respond(0, 2'b01);

    // Maximum length burst from requester 1 (ptr now 1).
    send_burst(1, 255, 1'b0, -1);
    respond(1, 2'b00);

    // Reset in the middle of a requester-1 burst returns ptr to 0.
    send_burst(0, 0, 1'b0, -1);
    respond(0, 2'b00);
    send_burst(1, 7, 1'b0, 2);
    axi_areset = 1'b1;
    #1;
    chk("midrst wvalid", 64'(m_wvalid), 64'd0);
    chk("midrst wdata", m_wdata, 64'd0);
    chk("midrst wlast", 64'(m_wlast), 64'd0);
    chk("midrst grant", 64'(grant), 64'd0);
    chk("midrst busy", 64'(busy), 64'd0);
    chk("midrst wready", 64'(req_wready), 64'd0);
    @(posedge axi_aclk); #1;
    axi_areset  = 1'b0;
    req_wvalid  = '0;
    m_wready    = 1'b0;
    req_awlen   = '0;
    req_awvalid = 2'b11;
    @(negedge axi_aclk);
    chk("postrst idle grant", 64'(grant), 64'd0);
    @(posedge axi_aclk); #1;
    @(negedge axi_aclk);
    chk("postrst grant", 64'(grant), 64'd1);
    chk("postrst awaddr", 64'(m_awaddr), 64'h1000);

`ifdef AXI_WR_ARB_TIMEOUT_EN
    do_reset();
    send_burst(0, 0, 1'b0, -1);
    for (int k = 1; k <= TO; k++) begin
      @(negedge axi_aclk);
      if (k < TO) begin
        chk($sformatf("to wait c%0d bvalid", k), 64'(req_bvalid), 64'd0);
        chk($sformatf("to wait c%0d err", k), 64'(err_timeout), 64'd0);
      end else begin
        chk("to fire bvalid", 64'(req_bvalid), 64'd1);
        chk("to fire bresp", 64'(req_bresp), 64'd2);
        chk("to fire err", 64'(err_timeout), 64'd1);
      end
      @(posedge axi_aclk); #1;
    end
    req_bready[0] = 1'b1;
    @(negedge axi_aclk);
    chk("to held bvalid", 64'(req_bvalid), 64'd1);
    @(posedge axi_aclk); #1;
    req_bready  = '0;
    req_awvalid = 2'b10;
    @(negedge axi_aclk);
    chk("stale bready", 64'(m_bready), 64'd1);
    chk("stale grant a", 64'(grant), 64'd0);
    @(posedge axi_aclk); #1;
    @(negedge axi_aclk);
    chk("stale grant b", 64'(grant), 64'd0);
    @(posedge axi_aclk); #1;
    m_bvalid = 1'b1;
    @(negedge axi_aclk);
    chk("stale drain bready", 64'(m_bready), 64'd1);
    @(posedge axi_aclk); #1;
    m_bvalid = 1'b0;
    @(negedge axi_aclk);
    chk("stale cleared idle", 64'(grant), 64'd0);
    @(posedge axi_aclk); #1;
    @(negedge axi_aclk);
    chk("after stale grant", 64'(grant), 64'd2);
    chk("err sticky", 64'(err_timeout), 64'd1);
`else
    chk("err tied low", 64'(err_timeout), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_wr_arbiter.md
# axi_wr_arbiter

Round-robin write-burst arbiter that shares one AXI write master port (AW/W/B) between NREQ requesters. It grants one requester at a time and forwards that requester's address, then exactly awlen+1 data beats with a generated wlast, then the write response. It sits between the write-capable clients and the AXI write-channel protocol FSM.

## Interface
- NREQ, 2 — number of requesters (2..4)
- AW, 32 — address width
- DW, 64 — data width; strobe width DW/8
- TO_CYCLES, 255 — B-response timeout in cycles (used only with AXI_WR_ARB_TIMEOUT_EN)

- axi_aclk  in  1  clock
- axi_areset  in  1  reset, asynchronous, active-high
- req_awvalid / req_awready  in / out  NREQ  per-requester address handshake
- req_awaddr, req_awlen, req_awsize, req_awburst  in  NREQ*AW, NREQ*8, NREQ*3, NREQ*2  packed address fields, requester i at slice i
- req_wvalid / req_wready  in / out  NREQ  per-requester data handshake
- req_wdata, req_wstrb  in  NREQ*DW, NREQ*DW/8  packed data
- req_bvalid / req_bready  out / in  NREQ  per-requester response handshake
- req_bresp  out  2  response code, valid for the requester whose req_bvalid is high
- m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid  out  AW, 8, 3, 2, 1  master address channel
- m_awready  in  1
- m_wdata, m_wstrb, m_wlast, m_wvalid  out  DW, DW/8, 1, 1  master data channel
- m_wready  in  1
- m_bresp, m_bvalid  in  2, 1;  m_bready  out  1  master response channel
- grant  out  NREQ  one-hot owner, 0 when idle
- busy  out  1  state != IDLE
- err_timeout  out  1  sticky, set on B timeout, cleared only by reset

## Operation
- States: IDLE, ADDR, DATA, RESP. Registered state, grant, rr pointer `ptr`, 8-bit beat counter `cnt`.
- IDLE: if any req_awvalid (and no stale response pending), pick the first set bit searching from ptr upward, wrapping. Register grant, go to ADDR. No request: stay.
- ADDR: m_aw* = combinational mux of the granted slice. m_awvalid = req_awvalid[g]; req_awready[g] = m_awready. On handshake: cnt <= m_awlen, go to DATA. If the requester drops awvalid, hold ADDR and grant.
- DATA: m_wdata/m_wstrb muxed from g. m_wvalid = req_wvalid[g]; req_wready[g] = m_wready; m_wlast = (cnt == 0). Each handshake does cnt <= cnt - 1. Handshake with cnt == 0 goes to RESP. Data from non-granted requesters is never forwarded.
- RESP: req_bvalid[g] = m_bvalid, req_bresp = m_bresp, m_bready = req_bready[g]. On handshake: ptr <= g+1 mod NREQ, grant <= 0, go to IDLE.
- All non-granted req_*ready and req_bvalid are 0. In IDLE, all m_*valid and m_bready are 0.
- Simultaneous requests: ptr decides priority. The requester just served has lowest priority next.
- awlen = 255 gives 256 beats; cnt never wraps below 0 within a burst.

## Timing
- Reset (async assert, sync-clean deassert): state IDLE, grant 0, ptr 0, cnt 0, busy 0, err_timeout 0, stale flag 0. Every output is 0 in reset.
- Grant latency: 1 cycle from req_awvalid in IDLE to m_awvalid.
- AW, W and B paths are combinational pass-through; no added latency per beat. Full throughput is 1 beat/cycle.
- IDLE→next grant: 1 idle cycle after each B handshake.
- Reset mid-burst: everything returns immediately to its reset values. The master-side partial burst is abandoned, and the downstream FSM is reset with it.

## Configuration
- AXI_WR_ARB_TIMEOUT_EN defined:
  - RESP runs a counter. If m_bvalid has not arrived after TO_CYCLES cycles, the arbiter drives req_bvalid[g] = 1 with req_bresp = 2'b10 (SLVERR) until req_bready[g], and sets err_timeout.
  - It then enters IDLE with the stale flag set. While stale is set: m_bready = 1, no new grant; the first m_bvalid clears stale.
- Not defined: RESP waits indefinitely. No counter or stale logic exists, and err_timeout is tied 0.

## Test plan
- Single burst: req0 awaddr 0x1000, awlen 3; wready always 1 → m_awvalid 1 cycle after request; 4 W beats with m_wlast only on beat 4; m_bresp 2'b00 routed to req_bvalid[0]; grant returns to 0.
- Contention: req0 and req1 both request at reset exit, awlen 0 each → req0 served first, then req1, then req0 again if it re-requests (round-robin order 0,1,0).
- Backpressure: m_wready toggling 1,0,1,0 with awlen 7 → exactly 8 beats forwarded, data in order, cnt unaffected by stalled cycles.
- Max length: awlen 255 → 256 beats, m_wlast on beat 256 only.
- Reset mid-DATA after beat 2 → all outputs 0 on the same edge; the next request is granted to req0 (ptr 0).
- With AXI_WR_ARB_TIMEOUT_EN and TO_CYCLES 16: no m_bvalid → at cycle 16 of RESP, req_bvalid[g] = 1 with bresp 2'b10 and err_timeout = 1; a late m_bvalid is drained with m_bready = 1 before the next grant.
